// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - NumIn-way arbitrated multiplexer with a one-word registered output stage.
// The output register reloads in the same cycle that it drains, so a steady stream runs without bubbles.
module arb_mux #(
   parameter int Size  = 32,
   parameter int NumIn = 4,
   parameter int Mode  = 1,
   localparam int SelW = (NumIn > 1) ? $clog2(NumIn) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NumIn*Size-1:0] in_data,
   input  logic [NumIn-1:0]      in_valid,
   output logic [NumIn-1:0]      in_ready,
   output logic [Size-1:0]       out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SelW-1:0]       out_sel
);

   logic [SelW-1:0] ptr;
   logic [SelW-1:0] grant_idx;
   logic            grant_found;
   logic            can_accept;
   logic            in_fire;
   logic [Size-1:0] sel_data;
   int              cand;

   // The search order starts at ptr in round-robin mode and at 0 in fixed-priority mode.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 0; k < NumIn; k++) begin
         cand = (Mode == 1) ? ((int'(ptr) + k) % NumIn) : k;
         if (!grant_found && in_valid[SelW'(cand)]) begin
            grant_found = 1'b1;
            grant_idx   = SelW'(cand);
         end
      end
      sel_data = '0;
      for (int i = 0; i < NumIn; i++) begin
         if (grant_idx == SelW'(i)) begin
            sel_data = in_data[i*Size +: Size];
         end
      end
      can_accept = !out_valid || out_ready;
      in_fire    = grant_found && can_accept && !reset;
      in_ready   = in_fire ? (NumIn'(1) << grant_idx) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else begin
         if (in_fire) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant_idx;
            ptr       <= (int'(grant_idx) == NumIn - 1) ? '0 : grant_idx + 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - scoreboard bench for arb_mux, round-robin and fixed-priority instances side by side.
// Both instances share stimulus; each has its own reference model and expected-word queue.
module tb_arb_mux;
   localparam int N = 4;
   localparam int W = 32;

   typedef struct {
      int         sel;
      logic [W-1:0] data;
   } word_t;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0]   in_valid = '0;
   logic           out_ready = 1'b0;

   logic [N-1:0]   rdy [2];
   logic [W-1:0]   od  [2];
   logic           ov  [2];
   logic [1:0]     os  [2];

   word_t          sb [2][$];
   int             ptr_m [2];
   logic [W-1:0]   exp_data [2];
   int             exp_sel [2];
   int             checks = 0;
   int             failures = 0;
   bit             armed = 1'b0;

   arb_mux #(.Size(W), .NumIn(N), .Mode(1)) u_rr (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy[1]), .out_data(od[1]), .out_valid(ov[1]),
      .out_ready(out_ready), .out_sel(os[1]));

   arb_mux #(.Size(W), .NumIn(N), .Mode(0)) u_fp (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy[0]), .out_data(od[0]), .out_valid(ov[0]),
      .out_ready(out_ready), .out_sel(os[0]));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the output register holds exactly the words accepted but not yet delivered.
   task automatic mon(input int m);
      logic [N-1:0] exp_ir;
      int           g;
      int           i;
      bit           can;
      word_t        w;
      check($sformatf("m%0d_out_valid", m), 64'(ov[m]), 64'(sb[m].size() > 0));
      check($sformatf("m%0d_out_data", m), 64'(od[m]), 64'(exp_data[m]));
      check($sformatf("m%0d_out_sel", m), 64'(os[m]), 64'(exp_sel[m]));
      exp_ir = '0;
      g = -1;
      if (!reset) begin
         can = (sb[m].size() == 0) || out_ready;
         for (int k = 0; k < N; k++) begin
            i = (m == 1) ? (ptr_m[m] + k) % N : k;
            if (g < 0 && in_valid[i]) g = i;
         end
         if (can && g >= 0) exp_ir[g] = 1'b1;
      end
      check($sformatf("m%0d_in_ready", m), 64'(rdy[m]), 64'(exp_ir));
      if (reset) begin
         sb[m].delete();
         ptr_m[m] = 0;
         exp_data[m] = '0;
         exp_sel[m] = 0;
         return;
      end
      if (sb[m].size() > 0 && out_ready) begin
         w = sb[m].pop_front();
         check($sformatf("m%0d_deliver_data", m), 64'(od[m]), 64'(w.data));
         check($sformatf("m%0d_deliver_sel", m), 64'(os[m]), 64'(w.sel));
      end
      if (exp_ir != '0) begin
         w.sel = g;
         w.data = in_data[g*W +: W];
         sb[m].push_back(w);
         exp_data[m] = w.data;
         exp_sel[m] = g;
         ptr_m[m] = (g + 1) % N;
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         mon(0);
         mon(1);
      end else if (reset) begin
         armed = 1'b1;
         for (int m = 0; m < 2; m++) begin
            sb[m].delete();
            ptr_m[m] = 0;
            exp_data[m] = '0;
            exp_sel[m] = 0;
         end
      end
   end

   task automatic drive(input logic [N-1:0] v, input logic r, input logic rst, input logic [N*W-1:0] d);
      @(posedge clk);
      #1;
      in_valid = v;
      out_ready = r;
      reset = rst;
      in_data = d;
   endtask

   function automatic logic [N*W-1:0] pack(input logic [W-1:0] d0, d1, d2, d3);
      return {d3, d2, d1, d0};
   endfunction

   logic [N*W-1:0] rd;
   logic [N-1:0]   rv;
   logic           rr;
   logic           rs;

   initial begin
      repeat (2) drive('0, 1'b0, 1'b1, '0);
      repeat (3) drive('0, 1'b1, 1'b0, '0);
      // all channels valid: round-robin walks 0,1,2,3 with no gaps
      repeat (8) drive(4'hF, 1'b1, 1'b0, pack(32'hA0, 32'hA1, 32'hA2, 32'hA3));
      repeat (2) drive('0, 1'b1, 1'b0, '0);
      repeat (6) drive(4'b1010, 1'b1, 1'b0, pack(32'h10, 32'h11, 32'h12, 32'h13));
      drive('0, 1'b1, 1'b0, '0);
      // stall with a held word, then drain and reload in the same cycle
      drive('0, 1'b0, 1'b1, '0);
      drive(4'b0100, 1'b0, 1'b0, pack(32'h0, 32'h0, 32'h1234, 32'h0));
      repeat (3) drive(4'b0001, 1'b0, 1'b0, pack(32'h5678, 32'h0, 32'h0, 32'h0));
      drive(4'b0001, 1'b1, 1'b0, pack(32'h5678, 32'h0, 32'h0, 32'h0));
      repeat (2) drive('0, 1'b1, 1'b0, '0);
      // pointer wrap: grant 2 leaves ptr at 3, lone channel 0 wins next
      drive('0, 1'b0, 1'b1, '0);
      drive(4'b0100, 1'b1, 1'b0, pack(32'h20, 32'h21, 32'h22, 32'h23));
      drive(4'b0001, 1'b1, 1'b0, pack(32'h30, 32'h31, 32'h32, 32'h33));
      drive(4'b1111, 1'b1, 1'b0, pack(32'h40, 32'h41, 32'h42, 32'h43));
      drive('0, 1'b1, 1'b0, '0);
      // reset while a word is held discards it
      drive('0, 1'b0, 1'b1, '0);
      drive(4'b0010, 1'b0, 1'b0, pack(32'h0, 32'hDEAD, 32'h0, 32'h0));
      drive('0, 1'b0, 1'b0, '0);
      drive('0, 1'b0, 1'b1, '0);
      repeat (3) drive('0, 1'b1, 1'b0, '0);
      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < N; c++) rd[c*W +: W] = $urandom;
         rv = N'($urandom);
         rr = ($urandom % 4) != 0;
         rs = ($urandom % 64) == 0;
         if (rs) rr = 1'b0;
         drive(rv, rr, rs, rd);
      end
      repeat (3) drive('0, 1'b1, 1'b0, '0);
      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
